// File: rtl/cpu6_bus_pkg.sv
// Shared state encodings, bus widths and fill values for the CPU6 external bus interface.
package cpu6_bus_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 8;

   // Read data returned when an access is aborted by the bus timeout
   localparam logic [DATA_W-1:0] TIMEOUT_FILL = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_DONE   = 2'd3
   } bus_state_t;

endpackage

// File: rtl/cpu6_wait_counter.sv
// Loadable counter with a terminal-count flag; counts down to zero for wait states,
// or up towards a limit when used as the bus timeout.
module cpu6_wait_counter
   import cpu6_bus_pkg::*;
#(
   parameter int               WIDTH    = 4,
   parameter bit               UP       = 1'b0,
   parameter logic [WIDTH-1:0] TERMINAL = '0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             enable,
   output logic             at_terminal
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (enable) begin
         count <= UP ? count + WIDTH'(1) : count - WIDTH'(1);
      end
   end

   assign at_terminal = (count == TERMINAL);

endmodule

// File: rtl/cpu6_bus_interface.sv
// CPU6 external bus interface: sequences address setup, strobes, wait states and data return.
// Optional abort of stalled accesses is enabled by defining BUS_TIMEOUT_EN.
module cpu6_bus_interface
   import cpu6_bus_pkg::*;
#(
   parameter int WAIT_STATES = 1,
   parameter int TIMEOUT     = 255
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_write,
   input  logic [15:0]       cpu_address,
   input  logic [7:0]        cpu_wdata,
   output logic [7:0]        cpu_rdata,
   output logic              cpu_ready,
   output logic              cpu_busy,
   output logic              cpu_error,
   output logic [15:0]       mem_address,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   output logic              mem_oe,
   output logic              mem_we,
   input  logic              mem_wait
);

   if (WAIT_STATES < 0 || WAIT_STATES > 15 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_params
      $error("cpu6_bus_interface: WAIT_STATES must be 0..15 and TIMEOUT 2..255");
   end

   bus_state_t state;
   logic       write_q;
   logic       wait_done;
   logic       normal_exit;

   cpu6_wait_counter #(
      .WIDTH    (4),
      .UP       (1'b0),
      .TERMINAL (4'd0)
   ) u_wait_counter (
      .clock       (clock),
      .reset       (reset),
      .load        (state == ST_SETUP),
      .load_value  (4'(WAIT_STATES)),
      .enable      ((state == ST_ACCESS) && !wait_done),
      .at_terminal (wait_done)
   );

   // mem_wait only counts once the programmed wait states have elapsed
   assign normal_exit = wait_done && !mem_wait;

`ifdef BUS_TIMEOUT_EN
   logic timeout_hit;
   logic timed_out;

   cpu6_wait_counter #(
      .WIDTH    (8),
      .UP       (1'b1),
      .TERMINAL (8'(TIMEOUT - 1))
   ) u_timeout_counter (
      .clock       (clock),
      .reset       (reset),
      .load        (state == ST_SETUP),
      .load_value  (8'd0),
      .enable      (state == ST_ACCESS),
      .at_terminal (timeout_hit)
   );
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= ST_IDLE;
         write_q     <= 1'b0;
         cpu_rdata   <= '0;
         cpu_ready   <= 1'b0;
         cpu_busy    <= 1'b0;
         cpu_error   <= 1'b0;
         mem_address <= '0;
         mem_wdata   <= '0;
         mem_oe      <= 1'b0;
         mem_we      <= 1'b0;
`ifdef BUS_TIMEOUT_EN
         timed_out   <= 1'b0;
`endif
      end else begin
         cpu_ready <= 1'b0;
         cpu_error <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cpu_req) begin
                  state       <= ST_SETUP;
                  cpu_busy    <= 1'b1;
                  write_q     <= cpu_write;
                  mem_address <= cpu_address;
                  if (cpu_write) begin
                     mem_wdata <= cpu_wdata;
                  end
               end
            end
            ST_SETUP: begin
               state  <= ST_ACCESS;
               mem_oe <= !write_q;
               mem_we <= write_q;
            end
            ST_ACCESS: begin
               if (normal_exit) begin
                  state  <= ST_DONE;
                  mem_oe <= 1'b0;
                  mem_we <= 1'b0;
                  if (!write_q) begin
                     cpu_rdata <= mem_rdata;
                  end
               end
`ifdef BUS_TIMEOUT_EN
               else if (timeout_hit) begin
                  state     <= ST_DONE;
                  mem_oe    <= 1'b0;
                  mem_we    <= 1'b0;
                  timed_out <= 1'b1;
                  if (!write_q) begin
                     cpu_rdata <= TIMEOUT_FILL;
                  end
               end
`endif
            end
            ST_DONE: begin
               // Address and write data stay on the bus through this cycle for hold time
               state     <= ST_IDLE;
               cpu_busy  <= 1'b0;
               cpu_ready <= 1'b1;
`ifdef BUS_TIMEOUT_EN
               cpu_error <= timed_out;
               timed_out <= 1'b0;
`endif
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu6_bus_interface.sv
// Self-checking bench for cpu6_bus_interface: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_cpu6_bus_interface;

   localparam int WS      = 1;
   localparam int TIMEOUT = 8;
`ifdef BUS_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset;
   logic        cpu_req;
   logic        cpu_write;
   logic [15:0] cpu_address;
   logic [7:0]  cpu_wdata;
   logic [7:0]  cpu_rdata;
   logic        cpu_ready;
   logic        cpu_busy;
   logic        cpu_error;
   logic [15:0] mem_address;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        mem_oe;
   logic        mem_we;
   logic        mem_wait;

   int n_cmp  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   cpu6_bus_interface #(
      .WAIT_STATES (WS),
      .TIMEOUT     (TIMEOUT)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .cpu_req     (cpu_req),
      .cpu_write   (cpu_write),
      .cpu_address (cpu_address),
      .cpu_wdata   (cpu_wdata),
      .cpu_rdata   (cpu_rdata),
      .cpu_ready   (cpu_ready),
      .cpu_busy    (cpu_busy),
      .cpu_error   (cpu_error),
      .mem_address (mem_address),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_oe      (mem_oe),
      .mem_we      (mem_we),
      .mem_wait    (mem_wait)
   );

   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // Transaction model: k counts cycles since the accepting edge (0 = idle);
   // end_k is the last ACCESS cycle once the exit has been decided.
   int          k = 0;
   int          end_k = 0;
   bit          m_write = 1'b0;
   bit          m_tmo = 1'b0;
   bit          exp_ready = 1'b0;
   bit          exp_error = 1'b0;
   logic [15:0] exp_addr = '0;
   logic [7:0]  exp_wdata = '0;
   logic [7:0]  exp_rdata = '0;

   always @(posedge clock) begin
      exp_ready = 1'b0;
      exp_error = 1'b0;
      if (reset) begin
         k = 0; end_k = 0; m_tmo = 1'b0;
         exp_addr = '0; exp_wdata = '0; exp_rdata = '0;
      end else if (k == 0) begin
         if (cpu_req) begin
            k = 1; end_k = 0; m_tmo = 1'b0;
            m_write  = cpu_write;
            exp_addr = cpu_address;
            if (cpu_write) exp_wdata = cpu_wdata;
         end
      end else if (end_k == 0) begin
         if (k >= 2) begin
            if ((k - 1) >= WS + 1 && !mem_wait) begin
               end_k = k;
               if (!m_write) exp_rdata = mem_rdata;
            end else if (TMO_EN && (k - 1) == TIMEOUT) begin
               end_k = k;
               m_tmo = 1'b1;
               if (!m_write) exp_rdata = 8'hFF;
            end
         end
         k++;
      end else begin
         k = 0;
         exp_ready = 1'b1;
         exp_error = m_tmo;
      end
   end

   always @(negedge clock) begin
      if (chk_en) begin
         chk("busy",      32'(cpu_busy),    32'(k != 0));
         chk("mem_oe",    32'(mem_oe),      32'(k >= 2 && end_k == 0 && !m_write));
         chk("mem_we",    32'(mem_we),      32'(k >= 2 && end_k == 0 && m_write));
         chk("ready",     32'(cpu_ready),   32'(exp_ready));
         chk("error",     32'(cpu_error),   32'(exp_error));
         chk("rdata",     32'(cpu_rdata),   32'(exp_rdata));
         chk("mem_addr",  32'(mem_address), 32'(exp_addr));
         chk("mem_wdata", 32'(mem_wdata),   32'(exp_wdata));
      end
   end

   // Issue one request at the current negedge and follow it until cpu_ready (bounded).
   // mem_wait is held high for wait_hi cycles starting in the cycle the wait counter expires.
   task automatic access(input bit wr, input logic [15:0] a, input logic [7:0] d,
                         input int wait_hi, input int max_c,
                         output int lat, output int oe_n, output int we_n,
                         output int rdy_n, output int err_n);
      lat = 0; oe_n = 0; we_n = 0; rdy_n = 0; err_n = 0;
      cpu_req = 1'b1; cpu_write = wr; cpu_address = a; cpu_wdata = d; mem_wait = 1'b0;
      @(negedge clock);
      cpu_req = 1'b0;
      for (int c = 1; c <= max_c; c++) begin
         mem_wait = (c >= 3 && c < 3 + wait_hi);
         oe_n += int'(mem_oe);
         we_n += int'(mem_we);
         if (cpu_ready) begin
            rdy_n++;
            if (cpu_error) err_n++;
            if (lat == 0) lat = c - 1;
         end
         if (lat != 0) break;
         @(negedge clock);
      end
      mem_wait = 1'b0;
   endtask

   int lat, oe_n, we_n, rdy_n, err_n;
   int stall_left;
   bit seen;

   initial begin
      reset = 1'b1; cpu_req = 1'b0; cpu_write = 1'b0; cpu_address = '0; cpu_wdata = '0;
      mem_rdata = '0; mem_wait = 1'b0;
      @(negedge clock);
      @(negedge clock);
      chk_en = 1'b1;
      chk("rst_rdata", 32'(cpu_rdata), 32'h00);
      chk("rst_busy",  32'(cpu_busy),  32'h0);
      chk("rst_oe_we", 32'({mem_oe, mem_we}), 32'h0);
      chk("rst_addr",  32'(mem_address), 32'h0000);
      reset = 1'b0;

      // Plain read
      mem_rdata = 8'h5A;
      access(1'b0, 16'h1234, 8'h00, 0, 40, lat, oe_n, we_n, rdy_n, err_n);
      chk("t1_latency", 32'(lat), 32'd4);
      chk("t1_oe_cycles", 32'(oe_n), 32'd2);
      chk("t1_we_cycles", 32'(we_n), 32'd0);
      chk("t1_rdata", 32'(cpu_rdata), 32'h5A);

      // Write leaves read data alone
      mem_rdata = 8'h99;
      access(1'b1, 16'hF200, 8'hA5, 0, 40, lat, oe_n, we_n, rdy_n, err_n);
      chk("t2_latency", 32'(lat), 32'd4);
      chk("t2_we_cycles", 32'(we_n), 32'd2);
      chk("t2_oe_cycles", 32'(oe_n), 32'd0);
      chk("t2_rdata_kept", 32'(cpu_rdata), 32'h5A);
      chk("t2_addr", 32'(mem_address), 32'hF200);
      chk("t2_wdata", 32'(mem_wdata), 32'hA5);

      // Read stretched by mem_wait
      mem_rdata = 8'hC3;
      access(1'b0, 16'h0042, 8'h00, 3, 40, lat, oe_n, we_n, rdy_n, err_n);
      chk("t3_latency", 32'(lat), 32'd7);
      chk("t3_oe_cycles", 32'(oe_n), 32'd5);
      chk("t3_rdata", 32'(cpu_rdata), 32'hC3);

      // Requests while busy are dropped; the one in the cycle after DONE is taken
      mem_rdata = 8'h77;
      cpu_req = 1'b1; cpu_write = 1'b0; cpu_address = 16'h0100;
      @(negedge clock);
      oe_n = 0; rdy_n = 0;
      for (int c = 1; c <= 4; c++) begin
         cpu_req = (c != 3); cpu_write = 1'b1; cpu_address = 16'hBEEF; cpu_wdata = 8'hEE;
         oe_n += int'(mem_oe);
         rdy_n += int'(cpu_ready);
         @(negedge clock);
      end
      rdy_n += int'(cpu_ready);
      chk("t4_ready_count", 32'(rdy_n), 32'd1);
      chk("t4_oe_cycles", 32'(oe_n), 32'd2);
      chk("t4_addr", 32'(mem_address), 32'h0100);
      chk("t4_rdata", 32'(cpu_rdata), 32'h77);
      cpu_req = 1'b1; cpu_write = 1'b1; cpu_address = 16'h0200; cpu_wdata = 8'h11;
      @(negedge clock);
      cpu_req = 1'b0;
      chk("t4_accept_busy", 32'(cpu_busy), 32'h1);
      chk("t4_accept_addr", 32'(mem_address), 32'h0200);
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clock);
         seen = cpu_ready;
      end
      chk("t4_second_done", 32'(seen), 32'h1);

      // Reset in the second ACCESS cycle
      @(negedge clock);
      mem_rdata = 8'h3E;
      cpu_req = 1'b1; cpu_write = 1'b0; cpu_address = 16'h4321;
      @(negedge clock);
      cpu_req = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("t5_oe", 32'(mem_oe), 32'h0);
      chk("t5_busy", 32'(cpu_busy), 32'h0);
      chk("t5_addr", 32'(mem_address), 32'h0000);
      rdy_n = 0;
      for (int c = 0; c < 5; c++) begin
         rdy_n += int'(cpu_ready);
         @(negedge clock);
      end
      chk("t5_no_ready", 32'(rdy_n), 32'd0);
      mem_rdata = 8'h6B;
      access(1'b0, 16'h4321, 8'h00, 0, 40, lat, oe_n, we_n, rdy_n, err_n);
      chk("t5_fresh_latency", 32'(lat), 32'd4);
      chk("t5_fresh_rdata", 32'(cpu_rdata), 32'h6B);

      // mem_wait stuck high
`ifdef BUS_TIMEOUT_EN
      mem_rdata = 8'h12;
      access(1'b0, 16'h0808, 8'h00, 1000, 40, lat, oe_n, we_n, rdy_n, err_n);
      chk("t6_oe_cycles", 32'(oe_n), 32'd8);
      chk("t6_latency", 32'(lat), 32'd10);
      chk("t6_error_with_ready", 32'(err_n), 32'd1);
      chk("t6_rdata_fill", 32'(cpu_rdata), 32'hFF);
      mem_rdata = 8'h3C;
      access(1'b0, 16'h0809, 8'h00, 6, 40, lat, oe_n, we_n, rdy_n, err_n);
      chk("t6_prio_oe_cycles", 32'(oe_n), 32'd8);
      chk("t6_prio_no_error", 32'(err_n), 32'd0);
      chk("t6_prio_rdata", 32'(cpu_rdata), 32'h3C);
`else
      mem_rdata = 8'h12;
      access(1'b0, 16'h0808, 8'h00, 1000, 301, lat, oe_n, we_n, rdy_n, err_n);
      chk("t6_no_completion", 32'(rdy_n), 32'd0);
      chk("t6_still_busy", 32'(cpu_busy), 32'h1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
`endif

      // Randomized traffic
      stall_left = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clock);
         cpu_req     = ($urandom_range(0, 2) == 0);
         cpu_write   = 1'($urandom_range(0, 1));
         cpu_address = 16'($urandom);
         cpu_wdata   = 8'($urandom);
         mem_rdata   = 8'($urandom);
         if (TMO_EN && stall_left == 0 && $urandom_range(0, 99) == 0) stall_left = 12;
         if (stall_left > 0) begin
            mem_wait = 1'b1;
            stall_left--;
         end else begin
            mem_wait = ($urandom_range(0, 3) == 0);
         end
         reset = ($urandom_range(0, 299) == 0);
      end
      @(negedge clock);
      reset = 1'b0; cpu_req = 1'b0; mem_wait = 1'b0;
      repeat (20) @(negedge clock);
      chk("final_idle", 32'(cpu_busy), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
